// File: rtl/io_pkg.sv
// Address-map constants shared by the CPU I/O read-path blocks.
package io_pkg;

  localparam logic [5:0] IO_BASE_IDX = 6'h24;
  localparam int         IO_ADDR_LSB = 2;
  localparam int         IO_ADDR_MSB = 7;
  localparam int         IO_DW       = 32;

  // The status word sits directly after the last data port.
  function automatic logic [5:0] io_status_idx(input logic [5:0] base, input int num_ports);
    return base + 6'(num_ports);
  endfunction

endpackage

// File: rtl/io_in_debounce.sv
// One input port: 2-flop synchroniser, optional stability filter, committed value.
// commit is high on every edge where stab is about to change.
module io_in_debounce #(
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = 0
) (
  input  logic              io_clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] stab,
  output logic              commit
);

  logic [DATA_W-1:0] s1_reg;
  logic [DATA_W-1:0] s2_reg;
  logic [DATA_W-1:0] stab_reg;
  logic [DATA_W-1:0] stab_next;

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      stab_reg <= '0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      stab_reg <= stab_next;
    end
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_nofilt
      assign stab_next = s2_reg;
    end else begin : g_filt
      localparam int CW = $clog2(DEBOUNCE_CYC + 1);

      logic [DATA_W-1:0] s2_prev_reg;
      logic [CW-1:0]     cnt_reg;
      logic [CW-1:0]     cnt_next;

      always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
          s2_prev_reg <= '0;
          cnt_reg     <= '0;
        end else begin
          s2_prev_reg <= s2_reg;
          cnt_reg     <= cnt_next;
        end
      end

      // cnt holds the number of repeat samples after a new value first appears at s2,
      // so the commit lands on the (DEBOUNCE_CYC+1)-th consecutive identical sample.
      always_comb begin
        cnt_next  = cnt_reg;
        stab_next = stab_reg;
        if ((s2_reg == stab_reg) || (s2_reg != s2_prev_reg)) begin
          cnt_next = '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
          stab_next = s2_reg;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
    end
  endgenerate

  assign stab   = stab_reg;
  assign commit = (stab_next != stab_reg);

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped bank of synchronised/debounced input ports with sticky,
// read-to-clear change flags and a maskable interrupt.
module io_input_bank
  import io_pkg::*;
#(
  parameter int                   NUM_PORTS    = 4,
  parameter int                   DATA_W       = 32,
  parameter logic [5:0]           BASE_IDX     = IO_BASE_IDX,
  parameter int                   DEBOUNCE_CYC = 0,
  parameter logic [NUM_PORTS-1:0] IRQ_MASK     = {NUM_PORTS{1'b1}}
) (
  input  logic                        io_clk,
  input  logic                        resetn,
  input  logic [31:0]                 addr,
  input  logic                        io_rd,
  input  logic [NUM_PORTS*DATA_W-1:0] in_port,
  output logic [31:0]                 io_read_data,
  output logic                        io_irq
);

  localparam logic [5:0] STATUS_IDX = io_status_idx(BASE_IDX, NUM_PORTS);

  generate
    if ((NUM_PORTS < 1) || (NUM_PORTS > 8) || (DATA_W < 1) || (DATA_W > 32) ||
        ((int'(BASE_IDX) + NUM_PORTS) > 63)) begin : g_param_err
      $error("io_input_bank: illegal NUM_PORTS/DATA_W/BASE_IDX combination");
    end
  endgenerate

  logic [DATA_W-1:0]    stab_w    [NUM_PORTS];
  logic [IO_DW-1:0]     port_word [NUM_PORTS];
  logic [NUM_PORTS-1:0] commit_w;
  logic [NUM_PORTS-1:0] chg_reg;
  logic [NUM_PORTS-1:0] chg_next;
  logic [NUM_PORTS-1:0] chg_clr;
  logic [5:0]           word_idx;
  logic                 status_hit;
  logic                 addr_unused;

  assign word_idx    = addr[IO_ADDR_MSB:IO_ADDR_LSB];
  assign addr_unused = ^{addr[31:IO_ADDR_MSB+1], addr[IO_ADDR_LSB-1:0]};

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      io_in_debounce #(
        .DATA_W       (DATA_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_port (
        .io_clk (io_clk),
        .resetn (resetn),
        .din    (in_port[gi*DATA_W +: DATA_W]),
        .stab   (stab_w[gi]),
        .commit (commit_w[gi])
      );
      assign port_word[gi] = IO_DW'(stab_w[gi]);
    end
  endgenerate

  always_comb begin
    io_read_data = '0;
    status_hit   = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (word_idx == BASE_IDX + 6'(k)) begin
        io_read_data = port_word[k];
      end
    end
    if (word_idx == STATUS_IDX) begin
      io_read_data = IO_DW'(chg_reg);
      status_hit   = 1'b1;
    end
  end

  // Clear only what the reader saw; a commit on the same edge re-sets its flag.
  always_comb begin
    chg_clr  = (io_rd && status_hit) ? chg_reg : '0;
    chg_next = (chg_reg & ~chg_clr) | commit_w;
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      chg_reg <= '0;
    end else begin
      chg_reg <= chg_next;
    end
  end

  assign io_irq = |(chg_reg & IRQ_MASK);

endmodule

// File: tb/tb_io_input_bank.sv
// Directed bench for io_input_bank: an unfiltered 32-bit instance and a
// DEBOUNCE_CYC=4, 8-bit instance, checked through an expected-value queue.
module tb_io_input_bank;

  logic         io_clk;
  logic         resetn;
  logic [31:0]  addr_a, addr_b;
  logic         io_rd_a, io_rd_b;
  logic [127:0] in_a;
  logic [31:0]  in_b;
  logic [31:0]  rdata_a, rdata_b;
  logic         irq_a, irq_b;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  io_input_bank #(
    .NUM_PORTS    (4),
    .DATA_W       (32),
    .DEBOUNCE_CYC (0)
  ) u_fast (
    .io_clk       (io_clk),
    .resetn       (resetn),
    .addr         (addr_a),
    .io_rd        (io_rd_a),
    .in_port      (in_a),
    .io_read_data (rdata_a),
    .io_irq       (irq_a)
  );

  io_input_bank #(
    .NUM_PORTS    (4),
    .DATA_W       (8),
    .DEBOUNCE_CYC (4)
  ) u_slow (
    .io_clk       (io_clk),
    .resetn       (resetn),
    .addr         (addr_b),
    .io_rd        (io_rd_b),
    .in_port      (in_b),
    .io_read_data (rdata_b),
    .io_irq       (irq_b)
  );

  initial begin
    io_clk = 1'b0;
    forever #5 io_clk = ~io_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%h required=queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
      end
      $display("txn %-12s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  task automatic read_a(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sb.push_back('{tag, exp});
    addr_a = a;
    #1;
    pop_cmp(rdata_a);
  endtask

  task automatic read_b(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sb.push_back('{tag, exp});
    addr_b = a;
    #1;
    pop_cmp(rdata_b);
  endtask

  task automatic irq_chk(input string tag, input int which, input logic exp);
    sb.push_back('{tag, {31'b0, exp}});
    pop_cmp({31'b0, (which == 0) ? irq_a : irq_b});
  endtask

  // Status read with io_rd held across one edge, then released.
  task automatic clr_b(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
    addr_b  = 32'hA0;
    io_rd_b = 1'b1;
    #1;
    pop_cmp(rdata_b);
    tick(1);
    io_rd_b = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    io_rd_a  = 1'b0;
    io_rd_b  = 1'b0;
    in_a     = '1;
    in_b     = '0;

    // Reset with all-ones inputs: everything reads zero.
    tick(2);
    for (int i = 0; i < 5; i++) begin
      read_a($sformatf("rst_a_%0d", i), 32'h90 + 32'(4 * i), 32'h0);
    end
    irq_chk("rst_irq_a", 0, 1'b0);
    irq_chk("rst_irq_b", 1, 1'b0);
    resetn = 1'b1;

    // Unfiltered latency: visible after edge 3, not edge 2.
    tick(2);
    read_a("lat_e2", 32'h90, 32'h0);
    tick(1);
    read_a("lat_e3", 32'h90, 32'hFFFF_FFFF);
    read_a("chg_a", 32'hA0, 32'hF);
    irq_chk("irq_a_set", 0, 1'b1);

    // Decode on the 32-bit instance.
    read_a("dec_8c", 32'h8C, 32'h0);
    read_a("dec_a4", 32'hA4, 32'h0);
    io_rd_a = 1'b1;
    read_a("rd_data_a", 32'h94, 32'hFFFF_FFFF);
    tick(1);
    io_rd_a = 1'b0;
    read_a("chg_kept_a", 32'hA0, 32'hF);
    in_a = '0;
    tick(3);
    read_a("dec_190", 32'h190, 32'h0);
    read_a("p0_zero_a", 32'h90, 32'h0);

    // Debounce: a 4-cycle pulse is filtered out.
    in_b[15:8] = 8'h1F;
    tick(4);
    in_b[15:8] = 8'h00;
    tick(8);
    read_b("glitch_p1", 32'h94, 32'h0);
    read_b("glitch_chg", 32'hA0, 32'h0);
    irq_chk("glitch_irq", 1, 1'b0);

    // A held value commits after edge 7, not edge 6.
    in_b[15:8] = 8'h1F;
    tick(6);
    read_b("p1_e6", 32'h94, 32'h0);
    tick(1);
    read_b("p1_e7", 32'h94, 32'h1F);
    read_b("chg_p1", 32'hA0, 32'h2);
    irq_chk("irq_p1", 1, 1'b1);

    // Read-to-clear.
    clr_b("clr_p1", 32'h2);
    read_b("chg_zero", 32'hA0, 32'h0);
    irq_chk("irq_zero", 1, 1'b0);
    in_b[7:0]   = 8'hA5;
    in_b[23:16] = 8'h3C;
    tick(7);
    read_b("chg_0101", 32'hA0, 32'h5);
    irq_chk("irq_0101", 1, 1'b1);
    read_b("p0_zext", 32'h90, 32'h0000_00A5);
    clr_b("clr_0101", 32'h5);
    irq_chk("irq_clr", 1, 1'b0);
    read_b("chg_after", 32'hA0, 32'h0);
    clr_b("clr_again", 32'h0);

    // Commit on the same edge as a clearing read keeps the flag.
    in_b[23:16] = 8'h44;
    tick(7);
    read_b("chg_p2", 32'hA0, 32'h4);
    in_b[23:16] = 8'h55;
    tick(6);
    read_b("p2_pre", 32'h98, 32'h44);
    clr_b("sim_clr", 32'h4);
    read_b("sim_chg", 32'hA0, 32'h4);
    irq_chk("sim_irq", 1, 1'b1);
    read_b("p2_new", 32'h98, 32'h55);

    // io_rd on a data address has no side effect.
    io_rd_b = 1'b1;
    read_b("rd_data_b", 32'h98, 32'h55);
    tick(1);
    io_rd_b = 1'b0;
    read_b("chg_kept_b", 32'hA0, 32'h4);
    clr_b("clr_p2", 32'h4);

    // Reset in the middle of a debounce window.
    in_b[31:24] = 8'h77;
    tick(5);
    read_b("p3_pre", 32'h9C, 32'h0);
    resetn = 1'b0;
    #1;
    read_b("mid_rst_p3", 32'h9C, 32'h0);
    read_b("mid_rst_chg", 32'hA0, 32'h0);
    irq_chk("mid_rst_irq", 1, 1'b0);
    tick(2);
    resetn = 1'b1;
    tick(6);
    read_b("p3_e6", 32'h9C, 32'h0);
    tick(1);
    read_b("p3_e7", 32'h9C, 32'h77);
    read_b("rst_chg", 32'hA0, 32'hF);
    irq_chk("rst_irq", 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
